// File: rtl/collision_pkg.sv
// Shared types and constants for the collision mixer slice.
//   rgb12_t : packed {r,g,b} colour, 4 bits per channel
//   state_t : collision-report FSM states
package collision_pkg;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

   typedef enum logic [1:0] {
      S_WAIT_SOF,
      S_ACCUM,
      S_REPORT
   } state_t;

   localparam int unsigned SCREEN_W_DEF = 640;
   localparam int unsigned SCREEN_H_DEF = 480;

endpackage

// File: rtl/collision_mixer_if.sv
// Pixel/sprite bundle between the raster source and sprite units (master)
// and the collision mixer (slave).
//   pxl_x/pxl_y           : current pixel coordinate
//   ghost_*/player_*      : per-pixel Draw + RGB from each sprite unit
//   Red/Green/Blue        : mixed output colour
//   collision_*           : once-per-frame collision pulses back to the units
//   hit_count             : saturating count of frames with a ghost/player overlap
interface collision_mixer_if;
   logic [31:0] pxl_x;
   logic [31:0] pxl_y;
   logic        ghost_draw;
   logic [11:0] ghost_rgb;
   logic        player_draw;
   logic [11:0] player_rgb;
   logic [3:0]  Red;
   logic [3:0]  Green;
   logic [3:0]  Blue;
   logic        collision_ghost;
   logic        collision_player;
   logic [7:0]  hit_count;

   modport master (
      output pxl_x, pxl_y, ghost_draw, ghost_rgb, player_draw, player_rgb,
      input  Red, Green, Blue, collision_ghost, collision_player, hit_count
   );

   modport slave (
      input  pxl_x, pxl_y, ghost_draw, ghost_rgb, player_draw, player_rgb,
      output Red, Green, Blue, collision_ghost, collision_player, hit_count
   );
endinterface

// File: rtl/collision_mixer_frame_sof_detect.sv
// Start-of-frame strobe: one cycle high when the raster arrives at (0,0).
//   clk, resetN   : clock, async active-low reset
//   pxl_x, pxl_y  : current pixel coordinate
//   sof           : combinational strobe, origin && !prev_origin
module frame_sof_detect (
   input  logic        clk,
   input  logic        resetN,
   input  logic [31:0] pxl_x,
   input  logic [31:0] pxl_y,
   output logic        sof
);

   logic origin;
   logic prev_origin;

   assign origin = (pxl_x == 32'd0) && (pxl_y == 32'd0);
   assign sof    = origin && !prev_origin;

   // Resets to 1 so coordinates parked at (0,0) across reset release do not
   // look like a fresh frame start.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) prev_origin <= 1'b1;
      else         prev_origin <= origin;
   end

endmodule

// File: rtl/collision_mixer.sv
// Collision mixer: priority-merges player, ghost and border layers into the
// output pixel (1-cycle latency), accumulates per-frame overlaps and returns
// one registered collision pulse per frame to each sprite unit.
//   clk, resetN : clock (one pixel per cycle), async active-low reset
//   bus         : collision_mixer_if slave (pixel in, colour/collisions out)
//
// state      | meaning
// S_WAIT_SOF | after reset; partial frame discarded, latches held clear
// S_ACCUM    | collecting overlap events for the current frame
// S_REPORT   | one cycle; collision pulses visible, hit_count updated
module collision_mixer
   import collision_pkg::*;
#(
   parameter int unsigned SCREEN_W   = SCREEN_W_DEF,
   parameter int unsigned SCREEN_H   = SCREEN_H_DEF,
   parameter int unsigned BORDER_W   = 8,
   parameter logic [11:0] BORDER_RGB = 12'hFFF,
   parameter logic [11:0] BG_RGB     = 12'h000
) (
   input  logic        clk,
   input  logic        resetN,
   collision_mixer_if.slave bus
);

   localparam logic [31:0] SW = 32'(SCREEN_W);
   localparam logic [31:0] SH = 32'(SCREEN_H);
   localparam logic [31:0] BW = 32'(BORDER_W);

   logic   in_screen, border_draw, ghost_draw, player_draw;
   logic   gp, gb, sof, report;
   logic   lat_gp_q, lat_gb_q, lat_gp_d, lat_gb_d;
   logic   coll_ghost_q, coll_player_q;
   logic [7:0] hit_count_q;
   rgb12_t rgb_d, rgb_q;
   state_t state_q, state_d;

   assign in_screen   = (bus.pxl_x < SW) && (bus.pxl_y < SH);
   assign border_draw = in_screen && ((bus.pxl_x < BW) || (bus.pxl_x >= SW - BW) ||
                                      (bus.pxl_y < BW) || (bus.pxl_y >= SH - BW));
   assign ghost_draw  = bus.ghost_draw  && in_screen;
   assign player_draw = bus.player_draw && in_screen;
   assign gp          = ghost_draw && player_draw;
   assign gb          = ghost_draw && border_draw;

   frame_sof_detect u_sof (
      .clk    (clk),
      .resetN (resetN),
      .pxl_x  (bus.pxl_x),
      .pxl_y  (bus.pxl_y),
      .sof    (sof)
   );

   always_comb begin
      rgb_d = rgb12_t'(12'h000);
      if (in_screen) begin
         if (player_draw)      rgb_d = rgb12_t'(bus.player_rgb);
         else if (ghost_draw)  rgb_d = rgb12_t'(bus.ghost_rgb);
         else if (border_draw) rgb_d = rgb12_t'(BORDER_RGB);
         else                  rgb_d = rgb12_t'(BG_RGB);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state_q <= S_WAIT_SOF;
      else         state_q <= state_d;
   end

   // The report decision is taken on the SOF cycle and registered, so the
   // pulses are high exactly while the FSM sits in S_REPORT. On every SOF the
   // latches restart from that pixel's own events: an overlap on the SOF
   // pixel belongs to the frame that is just beginning.
   always_comb begin
      state_d  = state_q;
      lat_gp_d = lat_gp_q;
      lat_gb_d = lat_gb_q;
      report   = 1'b0;
      case (state_q)
         S_WAIT_SOF: begin
            lat_gp_d = 1'b0;
            lat_gb_d = 1'b0;
            if (sof) begin
               state_d  = S_ACCUM;
               lat_gp_d = gp;
               lat_gb_d = gb;
            end
         end
         S_ACCUM: begin
            if (sof) begin
               state_d  = S_REPORT;
               report   = 1'b1;
               lat_gp_d = gp;
               lat_gb_d = gb;
            end else begin
               lat_gp_d = lat_gp_q | gp;
               lat_gb_d = lat_gb_q | gb;
            end
         end
         S_REPORT: begin
            state_d  = S_ACCUM;
            lat_gp_d = lat_gp_q | gp;
            lat_gb_d = lat_gb_q | gb;
         end
         default: begin
            state_d  = S_WAIT_SOF;
            lat_gp_d = 1'b0;
            lat_gb_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rgb_q         <= rgb12_t'(12'h000);
         lat_gp_q      <= 1'b0;
         lat_gb_q      <= 1'b0;
         coll_ghost_q  <= 1'b0;
         coll_player_q <= 1'b0;
         hit_count_q   <= 8'd0;
      end else begin
         rgb_q         <= rgb_d;
         lat_gp_q      <= lat_gp_d;
         lat_gb_q      <= lat_gb_d;
         coll_ghost_q  <= report && (lat_gp_q || lat_gb_q);
         coll_player_q <= report && lat_gp_q;
         if (report && lat_gp_q && (hit_count_q != 8'hFF))
            hit_count_q <= hit_count_q + 8'd1;
      end
   end

   assign bus.Red              = rgb_q.r;
   assign bus.Green            = rgb_q.g;
   assign bus.Blue             = rgb_q.b;
   assign bus.collision_ghost  = coll_ghost_q;
   assign bus.collision_player = coll_player_q;
   assign bus.hit_count        = hit_count_q;

endmodule

// File: tb/tb_collision_mixer.sv
module tb_collision_mixer;

   logic clk;
   logic resetN;
   int   checks;
   int   failures;
   int   hc_exp;

   collision_mixer_if bus();

   collision_mixer dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic        gd;
      logic [11:0] grgb;
      logic        pd;
      logic [11:0] prgb;
      logic [11:0] exp_rgb;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_coll(input string name, input logic g, input logic p, input int hc);
      check({name, "_cg"}, 32'(bus.collision_ghost), 32'(g));
      check({name, "_cp"}, 32'(bus.collision_player), 32'(p));
      check({name, "_hc"}, 32'(bus.hit_count), 32'(hc));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] x, input logic [31:0] y,
                        input logic gd, input logic [11:0] grgb,
                        input logic pd, input logic [11:0] prgb);
      bus.pxl_x       = x;
      bus.pxl_y       = y;
      bus.ghost_draw  = gd;
      bus.ghost_rgb   = grgb;
      bus.player_draw = pd;
      bus.player_rgb  = prgb;
   endtask

   task automatic pix(input logic [31:0] x, input logic [31:0] y, input logic gd, input logic pd);
      drive(x, y, gd, 12'h0F0, pd, 12'hF00);
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      hc_exp   = 0;

      vecs[0]  = '{x:120, y:40,  gd:1, grgb:12'h0F0, pd:1, prgb:12'hF00, exp_rgb:12'hF00};
      vecs[1]  = '{x:120, y:40,  gd:0, grgb:12'h0F0, pd:0, prgb:12'hF00, exp_rgb:12'h000};
      vecs[2]  = '{x:700, y:10,  gd:1, grgb:12'h0F0, pd:1, prgb:12'hF00, exp_rgb:12'h000};
      vecs[3]  = '{x:120, y:40,  gd:1, grgb:12'h0F0, pd:0, prgb:12'hF00, exp_rgb:12'h0F0};
      vecs[4]  = '{x:3,   y:100, gd:0, grgb:12'h0F0, pd:0, prgb:12'hF00, exp_rgb:12'hFFF};
      vecs[5]  = '{x:3,   y:100, gd:1, grgb:12'h0A5, pd:0, prgb:12'hF00, exp_rgb:12'h0A5};
      vecs[6]  = '{x:632, y:200, gd:0, grgb:12'h0F0, pd:0, prgb:12'hF00, exp_rgb:12'hFFF};
      vecs[7]  = '{x:631, y:200, gd:0, grgb:12'h0F0, pd:0, prgb:12'hF00, exp_rgb:12'h000};
      vecs[8]  = '{x:200, y:472, gd:0, grgb:12'h0F0, pd:0, prgb:12'hF00, exp_rgb:12'hFFF};
      vecs[9]  = '{x:200, y:471, gd:0, grgb:12'h0F0, pd:1, prgb:12'h123, exp_rgb:12'h123};
      vecs[10] = '{x:10,  y:480, gd:0, grgb:12'h0F0, pd:1, prgb:12'hF00, exp_rgb:12'h000};
      vecs[11] = '{x:639, y:479, gd:0, grgb:12'h0F0, pd:0, prgb:12'hF00, exp_rgb:12'hFFF};

      // Reset with coordinates parked at the origin
      resetN = 1'b0;
      drive(0, 0, 0, 12'h0F0, 0, 12'hF00);
      #3;
      check("rst_rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'h0);
      check_coll("rst", 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      resetN = 1'b1;
      tick();

      // Origin held after release: no false SOF, no pulse
      for (int i = 0; i < 5; i++) begin
         tick();
         check_coll("hold0", 0, 0, 0);
      end
      pix(5, 5, 0, 0);
      pix(0, 0, 0, 0);
      check_coll("first_sof", 0, 0, 0);

      // Ghost/player overlap for three pixels
      pix(100, 100, 1, 1);
      pix(101, 100, 1, 1);
      pix(102, 100, 1, 1);
      pix(300, 300, 0, 0);
      pix(0, 0, 0, 0);
      hc_exp = 1;
      check_coll("gp_report", 1, 1, hc_exp);
      for (int i = 0; i < 3; i++) begin
         pix(0, 0, 0, 0);
         check_coll("gp_hold", 0, 0, hc_exp);
      end
      pix(1, 0, 0, 0);
      check_coll("gp_after", 0, 0, hc_exp);

      // Ghost inside the border only
      pix(2, 50, 1, 0);
      pix(300, 300, 0, 0);
      pix(0, 0, 0, 0);
      check_coll("gb_report", 1, 0, hc_exp);
      pix(1, 0, 0, 0);
      check_coll("gb_after", 0, 0, hc_exp);

      // Mixer priority and border/off-screen table
      foreach (vecs[i]) begin
         drive(vecs[i].x, vecs[i].y, vecs[i].gd, vecs[i].grgb, vecs[i].pd, vecs[i].prgb);
         tick();
         check($sformatf("mix%0d", i), 32'({bus.Red, bus.Green, bus.Blue}), 32'(vecs[i].exp_rgb));
         check($sformatf("mix%0d_cg", i), 32'(bus.collision_ghost), 32'h0);
      end
      pix(0, 0, 0, 0);
      hc_exp = 2;
      check_coll("mix_report", 1, 1, hc_exp);

      // Overlap on the SOF pixel belongs to the new frame
      pix(50, 50, 0, 0);
      pix(0, 0, 1, 1);
      check_coll("sofpix_now", 0, 0, hc_exp);
      pix(50, 50, 0, 0);
      pix(0, 0, 0, 0);
      hc_exp = 3;
      check_coll("sofpix_next", 1, 1, hc_exp);

      // Saturation over 300 overlapping frames
      for (int i = 0; i < 300; i++) begin
         pix(100, 100, 1, 1);
         pix(0, 0, 0, 0);
         if (hc_exp < 255) hc_exp++;
         check($sformatf("sat%0d", i), 32'(bus.hit_count), 32'(hc_exp));
      end
      check("sat_final", 32'(bus.hit_count), 32'd255);

      // Mid-frame reset with lat_gp set
      pix(100, 100, 1, 1);
      drive(200, 200, 1, 12'h0F0, 1, 12'hF00);
      #3;
      resetN = 1'b0;
      #1;
      check("midrst_rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'h0);
      check_coll("midrst", 0, 0, 0);
      #1;
      resetN = 1'b1;
      tick();
      pix(300, 300, 0, 0);
      pix(0, 0, 0, 0);
      check_coll("post_rst_sof", 0, 0, 0);
      pix(100, 100, 1, 1);
      pix(5, 5, 0, 0);
      pix(0, 0, 0, 0);
      check_coll("post_rst_frame", 1, 1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
